// File: rtl/sa_pkg.sv
// Shared constants, FSM state type and row-unpack helper for the systolic-array result drain.
package sa_pkg;

  localparam int N        = 8;
  localparam int DATA_W   = 16;
  localparam int ROW_W    = $clog2(N);
  localparam int ROW_BITS = N * DATA_W;
  localparam int ARR_BITS = N * N * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SEND
  } drain_state_t;

  // Row r of the flattened array: Y_rc lives at bits [(r*N+c)*DATA_W +: DATA_W].
  function automatic logic [ROW_BITS-1:0] get_row(input logic [ARR_BITS-1:0] y,
                                                  input logic [ROW_W-1:0]    r);
    return y[int'(r)*ROW_BITS +: ROW_BITS];
  endfunction

endpackage

// File: rtl/sa_row_mux.sv
// Selects one row of the captured snapshot for the output stream; all outputs read 0 when
// no row is being offered.
module sa_row_mux
  import sa_pkg::*;
(
  input  logic [ARR_BITS-1:0] i_snap,
  input  logic [ROW_W-1:0]    i_row,
  input  logic                i_valid,
  output logic [ROW_BITS-1:0] o_data,
  output logic [ROW_W-1:0]    o_row,
  output logic                o_last
);

  always_comb begin
    o_data = '0;
    o_row  = '0;
    o_last = 1'b0;
    if (i_valid) begin
      o_data = get_row(i_snap, i_row);
      o_row  = i_row;
      o_last = (i_row == ROW_W'(N - 1));
    end
  end

endmodule

// File: rtl/sa_result_drain.sv
// Waits a fixed settle time after a matmul START, snapshots the whole result array, then
// streams it out one row per valid/ready beat so the array can be reloaded meanwhile.
module sa_result_drain
  import sa_pkg::*;
#(
  parameter int SETTLE_CYCLES = 22,
  parameter bit RELU_EN       = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [ARR_BITS-1:0] i_y_in,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [ROW_BITS-1:0] o_out_data,
  output logic [ROW_W-1:0]    o_out_row,
  output logic                o_out_last,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err_ovr
);

  drain_state_t        r_state;
  logic [7:0]          r_cnt;
  logic [ROW_W-1:0]    r_row;
  logic [ARR_BITS-1:0] r_snap;
  logic                r_done;
  logic                r_err;

  drain_state_t        w_next_state;
  logic [7:0]          w_next_cnt;
  logic [ROW_W-1:0]    w_next_row;
  logic                w_next_done;
  logic                w_capture;
  logic                w_busy;
  logic                w_valid;
  logic [ARR_BITS-1:0] w_snap_in;

  assign w_busy  = (r_state != ST_IDLE);
  assign w_valid = (r_state == ST_SEND);

  // Optional ReLU at capture: any word whose sign bit is set is stored as zero.
  always_comb begin
    w_snap_in = i_y_in;
    if (RELU_EN) begin
      for (int i = 0; i < N * N; i++) begin
        if (i_y_in[i*DATA_W + DATA_W - 1]) begin
          w_snap_in[i*DATA_W +: DATA_W] = '0;
        end
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_row   = r_row;
    w_next_done  = 1'b0;
    w_capture    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next_state = ST_WAIT;
          w_next_cnt   = 8'(SETTLE_CYCLES - 1);
        end
      end
      ST_WAIT: begin
        if (r_cnt == 8'd0) begin
          w_next_state = ST_SEND;
          w_next_row   = '0;
          w_capture    = 1'b1;
        end else begin
          w_next_cnt = r_cnt - 8'd1;
        end
      end
      ST_SEND: begin
        if (i_out_ready) begin
          if (r_row == ROW_W'(N - 1)) begin
            w_next_state = ST_IDLE;
            w_next_row   = '0;
            w_next_done  = 1'b1;
          end else begin
            w_next_row = r_row + 1'b1;
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // A START seen while busy never disturbs the running drain; it only latches the overrun flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_row   <= '0;
      r_snap  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_row   <= w_next_row;
      r_done  <= w_next_done;
      if (w_capture) begin
        r_snap <= w_snap_in;
      end
      if (i_start && w_busy) begin
        r_err <= 1'b1;
      end
    end
  end

  sa_row_mux u_row_mux (
    .i_snap  (r_snap),
    .i_row   (r_row),
    .i_valid (w_valid),
    .o_data  (o_out_data),
    .o_row   (o_out_row),
    .o_last  (o_out_last)
  );

  assign o_out_valid = w_valid;
  assign o_busy      = w_busy;
  assign o_done      = r_done;
  assign o_err_ovr   = r_err;

endmodule

// File: tb/tb_sa_result_drain.sv
// Directed, table-driven bench for sa_result_drain: default instance plus a SETTLE=1/ReLU instance.
module tb_sa_result_drain;

  typedef struct {
    logic start;
    logic ready;
    int   row;
    logic last;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start0, ready0, start1, ready1;
  logic [1023:0] y0, y1;
  logic          valid0, last0, busy0, done0, err0;
  logic          valid1, last1, busy1, done1, err1;
  logic [127:0]  data0, data1;
  logic [2:0]    row0, row1;

  int checks = 0;
  int errors = 0;

  vec_t basicQ[$];
  vec_t bpQ[$];
  vec_t ovrQ[$];
  vec_t finQ[$];

  always #5 clk = ~clk;

  sa_result_drain #(.SETTLE_CYCLES(22), .RELU_EN(1'b0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_y_in(y0),
    .o_out_valid(valid0), .i_out_ready(ready0), .o_out_data(data0), .o_out_row(row0),
    .o_out_last(last0), .o_busy(busy0), .o_done(done0), .o_err_ovr(err0)
  );

  sa_result_drain #(.SETTLE_CYCLES(1), .RELU_EN(1'b1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_y_in(y1),
    .o_out_valid(valid1), .i_out_ready(ready1), .o_out_data(data1), .o_out_row(row1),
    .o_out_last(last1), .o_busy(busy1), .o_done(done1), .o_err_ovr(err1)
  );

  // Expected row r of the 16'h(r*16+c) load pattern.
  function automatic logic [127:0] patRow(input int r);
    logic [127:0] w;
    w = '0;
    for (int c = 0; c < 8; c++) w[c*16 +: 16] = 16'(r * 16 + c);
    return w;
  endfunction

  function automatic logic [1023:0] patY();
    logic [1023:0] y;
    y = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) y[(r*8 + c)*16 +: 16] = 16'(r * 16 + c);
    return y;
  endfunction

  // Hand-derived ReLU expectation for the dut1 load (Y_00=8001, Y_01=7FFF, Y_25=C000).
  function automatic logic [127:0] reluRow(input int r);
    logic [127:0] w;
    w = patRow(r);
    if (r == 0) begin
      w[15:0]  = 16'h0000;
      w[31:16] = 16'h7FFF;
    end
    if (r == 2) w[5*16 +: 16] = 16'h0000;
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic rd);
    start0 = st;
    ready0 = rd;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Pulse START at a negedge, check the exact 22-cycle settle, optionally re-pulse during WAIT.
  task automatic startAndWait(input string tag, input bit ovrInWait);
    applyStimulus(1'b1, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    checkOutput({tag, " busy after start"}, 128'(busy0), 128'(1'b1));
    for (int k = 0; k < 21; k++) begin
      start0 = (ovrInWait && k == 5);
      @(negedge clk);
    end
    start0 = 1'b0;
    checkOutput({tag, " valid before settle"}, 128'(valid0), 128'(1'b0));
    checkOutput({tag, " err after wait"}, 128'(err0), 128'(ovrInWait));
    @(negedge clk);
    checkOutput({tag, " valid at settle"}, 128'(valid0), 128'(1'b1));
  endtask

  task automatic runTable(input string tag, input vec_t tbl[$]);
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].start, tbl[i].ready);
      checkOutput($sformatf("%s valid[%0d]", tag, i), 128'(valid0), 128'(1'b1));
      checkOutput($sformatf("%s row[%0d]", tag, i), 128'(row0), 128'(tbl[i].row));
      checkOutput($sformatf("%s data[%0d]", tag, i), data0, patRow(tbl[i].row));
      checkOutput($sformatf("%s last[%0d]", tag, i), 128'(last0), 128'(tbl[i].last));
      @(negedge clk);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput({tag, " done pulse"}, 128'(done0), 128'(1'b1));
    checkOutput({tag, " valid after drain"}, 128'(valid0), 128'(1'b0));
    checkOutput({tag, " idle after drain"}, 128'(busy0), 128'(1'b0));
    checkOutput({tag, " idle data zero"}, data0, 128'(0));
    @(negedge clk);
    checkOutput({tag, " done single"}, 128'(done0), 128'(1'b0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] held;
    int n;
    // Stimulus tables: {start, ready, expected row, expected last}.
    for (int i = 0; i < 8; i++) begin
      basicQ.push_back('{1'b0, 1'b1, i, (i == 7)});
      ovrQ.push_back('{(i == 3), 1'b1, i, (i == 7)});
      finQ.push_back('{(i == 7), 1'b1, i, (i == 7)});
    end
    bpQ.push_back('{1'b0, 1'b1, 0, 1'b0});
    bpQ.push_back('{1'b0, 1'b0, 1, 1'b0});
    bpQ.push_back('{1'b0, 1'b1, 1, 1'b0});
    bpQ.push_back('{1'b0, 1'b1, 2, 1'b0});
    bpQ.push_back('{1'b0, 1'b0, 3, 1'b0});
    bpQ.push_back('{1'b0, 1'b0, 3, 1'b0});
    bpQ.push_back('{1'b0, 1'b1, 3, 1'b0});
    bpQ.push_back('{1'b0, 1'b1, 4, 1'b0});
    bpQ.push_back('{1'b0, 1'b0, 5, 1'b0});
    bpQ.push_back('{1'b0, 1'b1, 5, 1'b0});
    bpQ.push_back('{1'b0, 1'b1, 6, 1'b0});
    bpQ.push_back('{1'b0, 1'b1, 7, 1'b1});

    // Reset with random activity on every input.
    rst_n = 1'b0;
    start1 = 1'b0;
    ready1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 32; w++) y0[w*32 +: 32] = $urandom;
      y1 = ~y0;
      applyStimulus(1'($urandom), 1'($urandom));
      start1 = 1'($urandom);
      @(negedge clk);
    end
    checkOutput("reset valid", 128'(valid0), 128'(0));
    checkOutput("reset data", data0, 128'(0));
    checkOutput("reset row", 128'(row0), 128'(0));
    checkOutput("reset last", 128'(last0), 128'(0));
    checkOutput("reset busy", 128'(busy0), 128'(0));
    checkOutput("reset done", 128'(done0), 128'(0));
    checkOutput("reset err", 128'(err0), 128'(0));
    applyStimulus(1'b0, 1'b0);
    start1 = 1'b0;
    y0 = patY();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset busy", 128'(busy0), 128'(0));
    checkOutput("post-reset valid", 128'(valid0), 128'(0));

    // Basic drain, all-ready.
    startAndWait("basic", 1'b0);
    runTable("basic", basicQ);
    checkOutput("basic row3 col5", 128'(patRow(3)[5*16 +: 16]), 128'(16'h0035));
    checkOutput("basic no err", 128'(err0), 128'(0));

    // Back-pressure with a fixed irregular ready pattern; also confirm a stalled row holds.
    startAndWait("bp", 1'b0);
    runTable("bp", bpQ);

    // Overrun: extra START in WAIT and again mid-SEND.
    startAndWait("ovr", 1'b1);
    runTable("ovr", ovrQ);
    repeat (3) @(negedge clk);
    checkOutput("ovr err sticky", 128'(err0), 128'(1'b1));
    doReset();
    checkOutput("ovr err cleared by reset", 128'(err0), 128'(0));

    // START coincident with the final handshake is dropped but still flags overrun.
    startAndWait("fin", 1'b0);
    runTable("fin", finQ);
    checkOutput("fin start ignored", 128'(busy0), 128'(0));
    checkOutput("fin err set", 128'(err0), 128'(1'b1));
    doReset();

    // Snapshot isolation: Y_IN goes all-ones the cycle after capture.
    startAndWait("iso", 1'b0);
    y0 = '1;
    runTable("iso", basicQ);
    y0 = patY();

    // SETTLE_CYCLES=1 with ReLU: capture on the edge after START.
    y1 = patY();
    y1[15:0] = 16'h8001;
    y1[31:16] = 16'h7FFF;
    y1[(2*8 + 5)*16 +: 16] = 16'hC000;
    start1 = 1'b1;
    ready1 = 1'b0;
    @(negedge clk);
    start1 = 1'b0;
    checkOutput("relu busy in wait", 128'(busy1), 128'(1'b1));
    checkOutput("relu valid in wait", 128'(valid1), 128'(0));
    @(negedge clk);
    checkOutput("relu valid after 1", 128'(valid1), 128'(1'b1));
    checkOutput("relu col0", 128'(data1[15:0]), 128'(16'h0000));
    checkOutput("relu col1", 128'(data1[31:16]), 128'(16'h7FFF));
    held = data1;
    @(negedge clk);
    checkOutput("relu stall hold", data1, held);
    ready1 = 1'b1;
    n = 0;
    for (int r = 0; r < 8; r++) begin
      checkOutput($sformatf("relu row[%0d]", r), 128'(row1), 128'(r));
      checkOutput($sformatf("relu data[%0d]", r), data1, reluRow(r));
      checkOutput($sformatf("relu last[%0d]", r), 128'(last1), 128'(r == 7));
      @(negedge clk);
    end
    ready1 = 1'b0;
    checkOutput("relu done", 128'(done1), 128'(1'b1));

    // Second run abandoned by reset mid-SEND.
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    ready1 = 1'b1;
    n = 0;
    while (!valid1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("relu2 reached send", 128'(valid1), 128'(1'b1));
    repeat (2) @(negedge clk);
    checkOutput("relu2 mid row", 128'(row1), 128'(2));
    ready1 = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("relu2 async valid", 128'(valid1), 128'(0));
    checkOutput("relu2 async busy", 128'(busy1), 128'(0));
    checkOutput("relu2 async data", data1, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("relu2 no done[%0d]", k), 128'(done1), 128'(0));
      checkOutput($sformatf("relu2 idle[%0d]", k), 128'(busy1), 128'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
